// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the clock divider bank.
//   CNT_W_DEF       : default counter / divisor width
//   DEFAULT_DIV_DEF : default reset divisor (tick period = D+1 cycles)
//   DIV_1HZ/DIV_1KHZ: divisors giving 1 Hz / 1 kHz clk_out from 50 MHz
//   ch_width()      : channel-select width, never less than 1
// ---------------------------------------------------------------------------
package clk_div_pkg;

  localparam int CNT_W_DEF       = 27;
  localparam int DEFAULT_DIV_DEF = 25000000;

  // clk_out period is 2*(D+1) cycles, so 50 MHz / (2*25e6) = 1 Hz.
  localparam int DIV_1HZ  = 24999999;
  localparam int DIV_1KHZ = 24999;

  // Smallest w >= 1 with 2**w >= n.
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// ---------------------------------------------------------------------------
// clk_div_chan
// One divider channel. Counts 0..div_act, emitting a one-cycle tick and
// toggling clk_out at the wrap. A written divisor waits in a shadow register
// and is committed only at a period boundary (wrap, disable or sync), so a
// reprogram never produces a short or long period.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_en       : run enable (level); low holds the channel in restart
//   i_sync     : one-cycle restart pulse, overrides i_en
//   i_wr       : divisor write strobe for this channel
//   i_wdata    : divisor value written to the shadow register
//   o_tick     : one-cycle pulse at the end of each period
//   o_clk_out  : 50% duty divided level
//   o_pend     : shadow divisor written, not yet committed
// ---------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_wr,
  input  logic [CNT_W-1:0] i_wdata,
  output logic             o_tick,
  output logic             o_clk_out,
  output logic             o_pend
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div_act;
  logic [CNT_W-1:0] r_div_shd;
  logic             r_pend;
  logic             r_tick;
  logic             r_clk_out;

  logic w_restart;
  logic w_wrap;
  logic w_commit;

  assign w_restart = i_sync || !i_en;
  assign w_wrap    = (r_cnt == r_div_act);
  // Every period boundary is a safe point to swap in the shadow divisor.
  assign w_commit  = w_restart || w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_div_act <= DIV_RST;
      r_div_shd <= DIV_RST;
      r_pend    <= 1'b0;
      r_tick    <= 1'b0;
      r_clk_out <= 1'b0;
    end else begin
      if (w_restart) begin
        r_cnt     <= '0;
        r_tick    <= 1'b0;
        r_clk_out <= 1'b0;
      end else if (w_wrap) begin
        r_cnt     <= '0;
        r_tick    <= 1'b1;
        r_clk_out <= ~r_clk_out;
      end else begin
        r_cnt     <= r_cnt + CNT_ONE;
        r_tick    <= 1'b0;
      end

      // The commit reads the shadow value from before this edge; a write on
      // the same edge lands in the shadow and stays pending for the next one.
      if (w_commit && r_pend) begin
        r_div_act <= r_div_shd;
      end

      if (i_wr) begin
        r_div_shd <= i_wdata;
        r_pend    <= 1'b1;
      end else if (w_commit) begin
        r_pend    <= 1'b0;
      end
    end
  end

  assign o_tick    = r_tick;
  assign o_clk_out = r_clk_out;
  assign o_pend    = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// ---------------------------------------------------------------------------
// clk_div_bank
// Bank of N_CH independent, runtime-programmable clock dividers sharing one
// system clock. Each channel gives a clock-enable tick and a 50% duty level.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : per-channel run enable (level)
//   sync       : one-cycle pulse restarting every channel in phase
//   cfg_we     : divisor write strobe
//   cfg_ch     : target channel (writes to channels >= N_CH are dropped)
//   cfg_div    : new divisor D (tick period D+1, clk_out period 2*(D+1))
//   tick       : per-channel one-cycle period pulse
//   clk_out    : per-channel divided level
//   pend       : per-channel shadow divisor awaiting commit
// ---------------------------------------------------------------------------
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter  int N_CH        = 4,
  parameter  int CNT_W       = CNT_W_DEF,
  parameter  int DEFAULT_DIV = DEFAULT_DIV_DEF,
  localparam int CH_W        = ch_width(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  en,
  input  logic             sync,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  pend
);

  logic [N_CH-1:0] w_wr;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    // An out-of-range cfg_ch matches no channel, so the write is dropped.
    assign w_wr[i] = cfg_we && (cfg_ch == CH_W'(i));

    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (en[i]),
      .i_sync    (sync),
      .i_wr      (w_wr[i]),
      .i_wdata   (cfg_div),
      .o_tick    (tick[i]),
      .o_clk_out (clk_out[i]),
      .o_pend    (pend[i])
    );
  end

endmodule
